// File: rtl/mealy_pattern_pkg.sv
// Shared types, default sizing and the pattern-length legality rule for the
// programmable Mealy pattern detector.
package mealy_pattern_pkg;

    localparam int unsigned DEF_MAX_LEN = 8;
    localparam int unsigned DEF_LEN_W   = 4;
    localparam int unsigned DEF_CNT_W   = 8;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_t;

    // A length is usable when the pattern has at least one bit and fits the history.
    function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
        return (len >= 1) && (len <= max_len);
    endfunction

endpackage

// File: rtl/mealy_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a simultaneous increment.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mealy_pattern_detector.sv
// Runtime-programmable serial pattern detector: z fires in the same cycle as the
// final matching bit, compared against recorded history masked to the loaded length.
module mealy_pattern_detector
    import mealy_pattern_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned LEN_W   = DEF_LEN_W,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               x,
    input  logic               x_valid,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               count_clr,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);

    state_t               state_q;
    logic [MAX_LEN-1:0]   pat_q;
    logic [LEN_W-1:0]     len_q;
    logic                 ovl_q;
    logic                 cfg_err_q;
    logic [MAX_LEN-2:0]   hist_q;
    logic [LEN_W-1:0]     fill_q;

    logic [MAX_LEN-1:0]   window;
    logic [MAX_LEN-1:0]   mask;
    logic                 accept;
    logic                 fill_ok;
    logic                 hit;
    logic                 load_legal;

    assign window     = {hist_q, x};
    assign accept     = (state_q == StRun) && x_valid && !load;
    // len_q is never 0 in StRun, so the subtraction cannot wrap while accept is high.
    assign fill_ok    = fill_q >= (len_q - LEN_W'(1));
    assign load_legal = len_legal(32'(pat_len), MAX_LEN);

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < 32'(len_q));
        end
    end

    assign hit = ((window ^ pat_q) & mask) == '0;
    assign z   = accept && fill_ok && hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            cfg_err_q <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
        end else if (load) begin
            hist_q <= '0;
            fill_q <= '0;
            if (load_legal) begin
                state_q   <= StRun;
                pat_q     <= pat;
                len_q     <= pat_len;
                ovl_q     <= overlap;
                cfg_err_q <= 1'b0;
            end else begin
                state_q   <= StIdle;
                cfg_err_q <= 1'b1;
            end
        end else if (accept) begin
            hist_q <= window[MAX_LEN-2:0];
            // Non-overlapping mode restarts the fill so old bits cannot join the next match.
            if (z && !ovl_q) begin
                fill_q <= '0;
            end else if (fill_q < FILL_MAX) begin
                fill_q <= fill_q + LEN_W'(1);
            end
        end
    end

    assign armed   = (state_q == StRun);
    assign cfg_err = cfg_err_q;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (z),
        .clr   (count_clr),
        .count (match_count)
    );

endmodule

// File: tb/tb_mealy_pattern_detector.sv
// Scoreboard bench: the driver pushes reference-model expectations, a monitor pops
// and compares z before each edge and the registered outputs just after it.
module tb_mealy_pattern_detector;

    logic       clock;
    logic       reset;
    logic       x;
    logic       x_valid;
    logic       load;
    logic [7:0] pat;
    logic [3:0] pat_len;
    logic       overlap;
    logic       count_clr;
    logic       z;
    logic [7:0] match_count;
    logic       armed;
    logic       cfg_err;

    mealy_pattern_detector #(
        .MAX_LEN (8),
        .LEN_W   (4),
        .CNT_W   (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .x           (x),
        .x_valid     (x_valid),
        .load        (load),
        .pat         (pat),
        .pat_len     (pat_len),
        .overlap     (overlap),
        .count_clr   (count_clr),
        .z           (z),
        .match_count (match_count),
        .armed       (armed),
        .cfg_err     (cfg_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic zv;
        logic z;
        int   cnt;
        logic armed;
        logic err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the list of bits that may still take part in a match.
    bit         live[$];
    logic       m_armed = 1'b0;
    logic       m_err   = 1'b0;
    logic [7:0] m_pat   = '0;
    int         m_len   = 0;
    logic       m_ovl   = 1'b0;
    int         m_cnt   = 0;

    logic [7:0] cur_p   = '0;
    logic [3:0] cur_l   = '0;
    logic       cur_o   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_hit();
        if (live.size() < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (live[live.size() - 1 - i] != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive(input logic xi, input logic xvi, input logic ldi, input logic [7:0] p,
                         input logic [3:0] pl, input logic ov, input logic cl, input logic rs);
        exp_t e;
        @(negedge clock);
        x = xi; x_valid = xvi; load = ldi; pat = p; pat_len = pl;
        overlap = ov; count_clr = cl; reset = rs;
        e.z  = 1'b0;
        e.zv = xvi || rs;
        if (rs) begin
            m_armed = 1'b0; m_err = 1'b0; m_cnt = 0; live.delete();
        end else begin
            if (m_armed && xvi && !ldi) begin
                live.push_back(xi);
                e.z = model_hit();
                if (e.z && !m_ovl) live.delete();
                if (live.size() > 16) void'(live.pop_front());
            end
            if (cl) m_cnt = 0;
            else if (e.z && m_cnt < 255) m_cnt++;
            if (ldi) begin
                live.delete();
                if (pl >= 1 && pl <= 8) begin
                    m_armed = 1'b1; m_err = 1'b0; m_pat = p; m_len = int'(pl); m_ovl = ov;
                end else begin
                    m_armed = 1'b0; m_err = 1'b1;
                end
            end
        end
        e.cnt = m_cnt; e.armed = m_armed; e.err = m_err;
        sb.push_back(e);
    endtask

    task automatic ld(input logic [7:0] p, input logic [3:0] pl, input logic ov);
        cur_p = p; cur_l = pl; cur_o = ov;
        drive(1'b0, 1'b0, 1'b1, p, pl, ov, 1'b0, 1'b0);
    endtask

    task automatic bitv(input logic b);
        drive(b, 1'b1, 1'b0, cur_p, cur_l, cur_o, 1'b0, 1'b0);
    endtask

    task automatic gap();
        drive(1'b0, 1'b0, 1'b0, cur_p, cur_l, cur_o, 1'b0, 1'b0);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bitv(v[i]);
    endtask

    // Monitor: z just before the edge, registered outputs just after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #4;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.zv) check("z", int'(z), int'(e.z));
                @(posedge clock);
                #1;
                check("match_count", int'(match_count), e.cnt);
                check("armed", int'(armed), int'(e.armed));
                check("cfg_err", int'(cfg_err), int'(e.err));
            end
        end
    end

    initial begin
        logic [31:0] stream;
        logic [3:0]  rl;
        int          r;
        reset = 1'b1; x = 1'b0; x_valid = 1'b0; load = 1'b0; pat = '0;
        pat_len = '0; overlap = 1'b0; count_clr = 1'b0;

        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
        gap();
        bitv(1'b1);

        stream = 32'b0_0100_1100_1001;
        ld(8'b0000_1001, 4'd4, 1'b1);
        send_bits(stream, 13);
        ld(8'b0000_1001, 4'd4, 1'b0);
        send_bits(stream, 13);

        ld(8'b0000_1001, 4'd0, 1'b1);
        send_bits(stream, 13);
        ld(8'b0000_1001, 4'd9, 1'b1);
        send_bits(stream, 13);
        ld(8'b0000_1001, 4'd4, 1'b1);
        send_bits(stream, 6);

        ld(8'b0000_0101, 4'd3, 1'b1);
        bitv(1'b1); bitv(1'b0); gap(); gap(); gap(); bitv(1'b1);
        ld(8'b0000_0101, 4'd3, 1'b1);
        bitv(1'b1); bitv(1'b0);
        drive(1'b1, 1'b1, 1'b1, cur_p, cur_l, cur_o, 1'b0, 1'b0);
        bitv(1'b1);

        ld(8'b0000_1001, 4'd4, 1'b1);
        bitv(1'b1); bitv(1'b0); bitv(1'b0);
        drive(1'b1, 1'b1, 1'b0, cur_p, cur_l, cur_o, 1'b0, 1'b1);
        gap();
        bitv(1'b1);
        ld(8'b0000_1001, 4'd4, 1'b1);
        bitv(1'b1);

        // Saturation of the 8-bit count, then clear racing a match.
        ld(8'b1111_1111, 4'd1, 1'b0);
        for (int i = 0; i < 260; i++) bitv(1'b1);
        drive(1'b1, 1'b1, 1'b0, cur_p, cur_l, cur_o, 1'b1, 1'b0);
        bitv(1'b1);
        bitv(1'b0);

        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                if ($urandom_range(0, 9) == 0) rl = 4'($urandom_range(0, 15));
                else rl = 4'($urandom_range(1, 8));
                cur_p = 8'($urandom); cur_l = rl; cur_o = 1'($urandom_range(0, 1));
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                      cur_p, cur_l, cur_o, 1'b0, 1'b0);
            end else begin
                drive(1'($urandom_range(0, 1)), r < 80, 1'b0, cur_p, cur_l, cur_o,
                      r == 99, 1'b0);
            end
        end

        gap();
        gap();
        @(negedge clock);
        @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
